// File: rtl/bit_perm_pkg.sv
// Shared definitions for the bit permutation engine: the configuration
// state encoding and the default DES P permutation table.
package bit_perm_pkg;

    // Configuration controller states
    typedef enum logic [1:0] {
        CFG_IDLE   = 2'd0,
        CFG_CHECK  = 2'd1,
        CFG_COMMIT = 2'd2
    } cfg_state_t;

    // DES P permutation, zero-based: destination i takes source DES_P[i]
    localparam int DES_P [32] = '{
        15,  6, 19, 20, 28, 11, 27, 16,
         0, 14, 22, 25,  4, 17, 30,  9,
         1,  7, 23, 13, 31, 26,  2,  8,
        18, 12, 29,  5, 21, 10,  3, 24
    };

    // Reset-time source for destination i: DES P at 32 bits, identity otherwise
    function automatic int default_src(input int w, input int i);
        if (w == 32) begin
            return DES_P[i[4:0]];
        end
        return i;
    endfunction

endpackage

// File: rtl/perm_core.sv
// Combinational bit permutation network. Position 0 is the MSB of the word.
// Forward: out[i] = in[tbl[i]]. Inverse: out[tbl[i]] = in[i].
module perm_core #(
    parameter int W  = 32,
    parameter int IW = $clog2(W)
) (
    input  logic [W-1:0]    word,
    input  logic [W*IW-1:0] tbl,
    input  logic            inv,
    output logic [W-1:0]    result
);

    // Words re-indexed so that bit p holds position p
    logic [W-1:0]  in_pos;
    logic [W-1:0]  fwd_pos;
    logic [W-1:0]  inv_pos;
    logic [W-1:0]  res_pos;
    logic [IW-1:0] src [W];

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_fwd
            assign in_pos[gi]      = word[W-1-gi];
            assign src[gi]         = tbl[gi*IW +: IW];
            assign fwd_pos[gi]     = in_pos[src[gi]];
            assign result[W-1-gi]  = res_pos[gi];
        end

        // Inverse: each destination collects the single source that maps onto it
        for (genvar gj = 0; gj < W; gj++) begin : g_inv
            logic [W-1:0] hit;
            for (genvar gi = 0; gi < W; gi++) begin : g_hit
                assign hit[gi] = (src[gi] == IW'(gj)) & in_pos[gi];
            end
            assign inv_pos[gj] = |hit;
        end
    endgenerate

    assign res_pos = inv ? inv_pos : fwd_pos;

endmodule

// File: rtl/bit_perm_engine.sv
// Bit permutation engine: one registered valid/ready datapath stage driven
// by an active permutation table, plus a shadow table that is checked for
// being a bijection before it is copied into the active table.
module bit_perm_engine
    import bit_perm_pkg::*;
#(
    parameter int W  = 32,
    parameter int IW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_inv,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    input  logic          tbl_wr,
    input  logic [IW-1:0] tbl_idx,
    input  logic [IW-1:0] tbl_src,
    input  logic          tbl_commit,
    output logic          cfg_busy,
    output logic          cfg_done,
    output logic          cfg_err
);

    localparam logic [IW:0]   W_EXT  = (IW+1)'(W);
    localparam logic [IW-1:0] K_LAST = IW'(W-1);

    cfg_state_t    state_reg;
    logic [IW-1:0] k_reg;
    logic [W-1:0]  seen_reg;
    logic          err_acc_reg;
    logic          err_pend_reg;
    logic          cfg_done_reg;
    logic          cfg_err_reg;
    logic          out_valid_reg;
    logic [W-1:0]  out_data_reg;

    logic [IW-1:0]   shadow_reg [W];
    logic [IW-1:0]   active_reg [W];
    logic [W*IW-1:0] active_flat;
    logic [W-1:0]    perm_result;

    logic          idx_ok;
    logic          wr_fire;
    logic          commit_fire;
    logic [IW-1:0] cur_src;
    logic          cur_oor;
    logic          cur_err;
    logic          beat_fire;

    // Table writes only land while idle and for an in-range destination
    assign idx_ok      = {1'b0, tbl_idx} < W_EXT;
    assign wr_fire     = (state_reg == CFG_IDLE) && tbl_wr && idx_ok;
    assign commit_fire = (state_reg == CFG_COMMIT);

    // Entry under inspection during CHECK; out-of-range sources are errors
    assign cur_src = shadow_reg[k_reg];
    assign cur_oor = {1'b0, cur_src} >= W_EXT;
    assign cur_err = cur_oor || seen_reg[cur_src];

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_tbl
            localparam logic [IW-1:0] DEF_SRC = IW'(default_src(W, gi));

            // Shadow entry: reset default, then host writes while idle
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_reg[gi] <= DEF_SRC;
                end else if (wr_fire && (tbl_idx == IW'(gi))) begin
                    shadow_reg[gi] <= tbl_src;
                end
            end

            // Active entry: only replaced by a validated shadow in COMMIT
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    active_reg[gi] <= DEF_SRC;
                end else if (commit_fire) begin
                    active_reg[gi] <= shadow_reg[gi];
                end
            end

            assign active_flat[gi*IW +: IW] = active_reg[gi];
        end
    endgenerate

    perm_core #(
        .W  (W),
        .IW (IW)
    ) u_core (
        .word   (in_data),
        .tbl    (active_flat),
        .inv    (in_inv),
        .result (perm_result)
    );

    assign in_ready  = !out_valid_reg || out_ready;
    assign beat_fire = in_valid && in_ready;

    // Output register: load on an accepted beat, hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (beat_fire) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= perm_result;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Config controller: walk the shadow once, mark seen sources, then commit
    // or reject. A rejection is reported one cycle after CHECK ends so that
    // both outcomes arrive W+1 cycles after the commit request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= CFG_IDLE;
            k_reg        <= '0;
            seen_reg     <= '0;
            err_acc_reg  <= 1'b0;
            err_pend_reg <= 1'b0;
            cfg_done_reg <= 1'b0;
            cfg_err_reg  <= 1'b0;
        end else begin
            cfg_done_reg <= 1'b0;
            cfg_err_reg  <= err_pend_reg;
            err_pend_reg <= 1'b0;
            case (state_reg)
                CFG_IDLE: begin
                    if (tbl_commit) begin
                        state_reg   <= CFG_CHECK;
                        k_reg       <= '0;
                        seen_reg    <= '0;
                        err_acc_reg <= 1'b0;
                    end
                end
                CFG_CHECK: begin
                    if (!cur_oor) begin
                        seen_reg[cur_src] <= 1'b1;
                    end
                    err_acc_reg <= err_acc_reg | cur_err;
                    if (k_reg == K_LAST) begin
                        k_reg <= '0;
                        if (err_acc_reg || cur_err) begin
                            state_reg    <= CFG_IDLE;
                            err_pend_reg <= 1'b1;
                        end else begin
                            state_reg <= CFG_COMMIT;
                        end
                    end else begin
                        k_reg <= k_reg + IW'(1);
                    end
                end
                CFG_COMMIT: begin
                    state_reg    <= CFG_IDLE;
                    cfg_done_reg <= 1'b1;
                end
                default: begin
                    state_reg <= CFG_IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign cfg_busy  = (state_reg != CFG_IDLE);
    assign cfg_done  = cfg_done_reg;
    assign cfg_err   = cfg_err_reg;

endmodule

// File: tb/tb_bit_perm_engine.sv
// Self-checking bench for bit_perm_engine (W=32): vector table, scoreboard
// queue fed on accepted beats, and hand sequences for configuration timing,
// backpressure and reset during validation.
module tb_bit_perm_engine;

    localparam int W  = 32;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_inv = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic          tbl_wr = 1'b0;
    logic [IW-1:0] tbl_idx = '0;
    logic [IW-1:0] tbl_src = '0;
    logic          tbl_commit = 1'b0;
    logic          cfg_busy;
    logic          cfg_done;
    logic          cfg_err;

    always #5 clk = ~clk;

    bit_perm_engine #(.W(W), .IW(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_inv     (in_inv),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .tbl_wr     (tbl_wr),
        .tbl_idx    (tbl_idx),
        .tbl_src    (tbl_src),
        .tbl_commit (tbl_commit),
        .cfg_busy   (cfg_busy),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err)
    );

    typedef struct {
        logic [31:0] din;
        bit          inv;
        logic [31:0] exp;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q [$];
    vec_t        vecs [8];
    int          model_tbl [32];
    int          tb_des [32] = '{
        15,  6, 19, 20, 28, 11, 27, 16,
         0, 14, 22, 25,  4, 17, 30,  9,
         1,  7, 23, 13, 31, 26,  2,  8,
        18, 12, 29,  5, 21, 10,  3, 24
    };

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    // Reference permutation, position 0 = MSB
    function automatic logic [31:0] model_perm(input logic [31:0] d, input bit inv);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (!inv) r = r | (((d >> (31 - model_tbl[i])) & 32'd1) << (31 - i));
            else      r = r | (((d >> (31 - i)) & 32'd1) << (31 - model_tbl[i]));
        end
        return r;
    endfunction

    // Scoreboard: every result handed downstream is compared with the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out actual=%h required=none", out_data);
            end else begin
                check_eq("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] d, input bit inv, input logic [31:0] e);
        bit done;
        done = 1'b0;
        in_data  = d;
        in_inv   = inv;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=no_ready required=ready");
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && exp_q.size() != 0; t++) @(negedge clk);
        check_eq("drain_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) send(vecs[i].din, vecs[i].inv, vecs[i].exp);
        in_valid = 1'b0;
        drain();
    endtask

    task automatic run_random(input int n);
        logic [31:0] d;
        bit          inv;
        for (int i = 0; i < n; i++) begin
            d   = $urandom;
            inv = 1'($urandom_range(0, 1));
            send(d, inv, model_perm(d, inv));
        end
        in_valid = 1'b0;
        drain();
    endtask

    task automatic write_entry(input logic [4:0] idx, input logic [4:0] src);
        tbl_wr  = 1'b1;
        tbl_idx = idx;
        tbl_src = src;
        @(posedge clk); #1;
        tbl_wr  = 1'b0;
    endtask

    // Commit and time the result pulse; optionally write alongside the commit
    // and/or poke a write into the busy window (which must be ignored).
    task automatic do_commit(input int exp_done_n, input int exp_err_n, input int inject_n,
                             input bit co_wr, input logic [4:0] co_idx, input logic [4:0] co_src);
        int done_n, err_n, pulses;
        bit busy_ok;
        done_n = -1; err_n = -1; pulses = 0; busy_ok = 1'b1;
        tbl_commit = 1'b1;
        tbl_wr  = co_wr;
        tbl_idx = co_idx;
        tbl_src = co_src;
        @(posedge clk); #1;
        tbl_commit = 1'b0;
        tbl_wr     = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tbl_wr  = (n == inject_n);
            tbl_idx = 5'd3;
            tbl_src = 5'd7;
            @(posedge clk); #1;
            if (cfg_done) begin if (done_n < 0) done_n = n; pulses++; end
            if (cfg_err)  begin if (err_n < 0)  err_n = n;  pulses++; end
            if (n <= 31 && !cfg_busy) busy_ok = 1'b0;
            if (n == 33 && cfg_busy)  busy_ok = 1'b0;
        end
        tbl_wr = 1'b0;
        check_eq("cfg_done_cycle", 32'(done_n), 32'(exp_done_n));
        check_eq("cfg_err_cycle", 32'(err_n), 32'(exp_err_n));
        check_eq("cfg_pulse_count", 32'(pulses), 32'd1);
        check_eq("cfg_busy_window", 32'(busy_ok), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_a;
        int pulses;

        vecs[0] = '{32'h8000_0000, 1'b0, 32'h0080_0000};
        vecs[1] = '{32'h0001_0000, 1'b0, 32'h8000_0000};
        vecs[2] = '{32'h0080_0000, 1'b1, 32'h8000_0000};
        vecs[3] = '{32'h8000_0000, 1'b1, 32'h0001_0000};
        vecs[4] = '{32'h0000_0001, 1'b0, 32'h0000_0800};
        vecs[5] = '{32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF};
        vecs[6] = '{32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[7] = '{32'h0000_0800, 1'b1, 32'h0000_0001};
        model_tbl = tb_des;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", out_data, 32'd0);
        check_eq("rst_cfg_busy", 32'(cfg_busy), 32'd0);
        check_eq("rst_cfg_done", 32'(cfg_done), 32'd0);
        check_eq("rst_cfg_err", 32'(cfg_err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);

        // Default DES table: constant vectors and random round trips
        run_vecs();
        run_random(8);

        // Backpressure: one beat held while a second waits, then streaming
        out_ready = 1'b0;
        exp_a = model_perm(32'hA5A5_0F0F, 1'b0);
        send(32'hA5A5_0F0F, 1'b0, exp_a);
        in_data  = 32'h1357_9BDF;
        in_inv   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
            check_eq("stall_out_data", out_data, exp_a);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'h1357_9BDF, 1'b0, model_perm(32'h1357_9BDF, 1'b0));
        send(32'h2468_ACE0, 1'b1, model_perm(32'h2468_ACE0, 1'b1));
        send(32'hDEAD_BEEF, 1'b0, model_perm(32'hDEAD_BEEF, 1'b0));
        in_valid = 1'b0;
        drain();

        // Duplicate entry: rejected at commit+33, DES stays active
        for (int i = 0; i < 32; i++) write_entry(5'(i), 5'(i));
        write_entry(5'd5, 5'd4);
        do_commit(-1, 33, 0, 1'b0, 5'd0, 5'd0);
        run_vecs();

        // Valid identity, with a write attempted mid-CHECK that must be ignored
        write_entry(5'd5, 5'd5);
        do_commit(33, -1, 10, 1'b0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) model_tbl[i] = i;
        send(32'h1234_5678, 1'b0, 32'h1234_5678);
        send(32'h1000_0000, 1'b0, 32'h1000_0000);
        in_valid = 1'b0;
        drain();
        run_random(6);

        // Write in the commit cycle is validated: creates a duplicate, rejected
        do_commit(-1, 33, 0, 1'b1, 5'd0, 5'd1);
        send(32'h1234_5678, 1'b1, 32'h1234_5678);
        in_valid = 1'b0;
        drain();

        // Reset 10 cycles into CHECK: no result pulse, DES table restored
        write_entry(5'd0, 5'd0);
        tbl_commit = 1'b1;
        @(posedge clk); #1;
        tbl_commit = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_busy", 32'(cfg_busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (cfg_done || cfg_err) pulses++;
        end
        check_eq("rst_mid_pulses", 32'(pulses), 32'd0);
        model_tbl = tb_des;
        run_vecs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
